uart_tx: RTL and testbench

Asynchronous serial transmitter: accepts one byte per valid/ready handshake and drives it out LSB-first on a single line as start bit, data bits, optional parity bit and stop bit, each held for a fixed number of clock cycles. It drives the line toward an off-chip UART receiver or the team's serial receive block. It is the transmitting end of the same point-to-point link.

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define PARITY_EN to insert the parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef PARITY_EN
        , StParity
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_d, ready_d, done_d;
    logic                 bit_end;
`ifdef PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_valid && tx_ready) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = tx_data;
`ifdef PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
`ifdef PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registered line lines up with it.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
`ifdef PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == StIdle);
        done_d  = (state_q == StStop) && bit_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            tx_ready <= ready_d;
            tx_done  <= done_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a byte scoreboard and cycle-exact line checks.
module tb_uart_tx;

    localparam int N  = 4;
    localparam int DB = 8;
`ifdef PARITY_EN
    localparam int F = DB + 3;
`else
    localparam int F = DB + 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];

    uart_tx #(
        .CLKS_PER_BIT(N),
        .DATA_BITS   (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with tx_valid already high; returns #1 after the accept edge.
    task automatic wait_accept();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", tx_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Checks every cycle of one frame, from accept+1 through the tx_done cycle.
    task automatic check_frame();
        logic [7:0] d;
        logic       e;
        int         slot;
        chk("sb_nonempty", sb_q.size() != 0, 1);
        d = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
        for (int c = 1; c <= F * N; c++) begin
            @(negedge clk);
            slot = (c - 1) / N;
            if (slot == 0) e = 1'b0;
            else if (slot <= DB) e = d[slot-1];
`ifdef PARITY_EN
            else if (slot == DB + 1) e = ^d;
`endif
            else e = 1'b1;
            chk($sformatf("tx[%0h] c%0d", d, c), tx, e);
            chk($sformatf("ready_busy[%0h] c%0d", d, c), tx_ready, 0);
            chk($sformatf("done_busy[%0h] c%0d", d, c), tx_done, 0);
        end
        @(negedge clk);
        chk($sformatf("done_pulse[%0h]", d), tx_done, 1);
        chk($sformatf("ready_back[%0h]", d), tx_ready, 1);
        chk($sformatf("tx_idle_gap[%0h]", d), tx, 1);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk($sformatf("%s tx c%0d", tag, i), tx, 1);
            chk($sformatf("%s done c%0d", tag, i), tx_done, 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", tx_ready, 1);
        chk("reset_done", tx_done, 0);
        rst = 1'b0;
        check_quiet("idle100", 100);

        // Single frame 0x55
        tx_data = 8'h55; tx_valid = 1'b1; sb_q.push_back(8'h55);
        wait_accept();
        tx_valid = 1'b0;
        check_frame();

        // Back-to-back 0x00 then 0xFF with tx_valid held; first accept coincides with tx_done
        tx_data = 8'h00; tx_valid = 1'b1; sb_q.push_back(8'h00);
        wait_accept();
        tx_data = 8'hFF; sb_q.push_back(8'hFF);
        check_frame();
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_frame();

        // Request during an active frame is ignored
        tx_data = 8'hA5; tx_valid = 1'b1; sb_q.push_back(8'hA5);
        wait_accept();
        tx_valid = 1'b0;
        fork
            check_frame();
            begin
                repeat (10) @(negedge clk);
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check_quiet("after_a5", 20);

        // Reset mid-frame while the line is low
        tx_data = 8'h00; tx_valid = 1'b1; sb_q.push_back(8'h00);
        wait_accept();
        tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("tx_before_rst", tx, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_ready", tx_ready, 1);
        chk("rst_async_done", tx_done, 0);
        void'(sb_q.pop_front());
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_done", tx_done, 0);
            chk("rst_hold_tx", tx, 1);
        end
        rst = 1'b0;
        check_quiet("after_rst", 5);

        tx_data = 8'h81; tx_valid = 1'b1; sb_q.push_back(8'h81);
        wait_accept();
        tx_valid = 1'b0;
        check_frame();

        // Parity-sensitive patterns (odd and even popcount)
        tx_data = 8'h07; tx_valid = 1'b1; sb_q.push_back(8'h07);
        wait_accept();
        tx_valid = 1'b0;
        check_frame();
        tx_data = 8'h03; tx_valid = 1'b1; sb_q.push_back(8'h03);
        wait_accept();
        tx_valid = 1'b0;
        check_frame();
        check_quiet("final", 10);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
